// File: rtl/wf_fetch_ctrl_if.sv
// Weight path between the fetch sequencer, the weight ROM and the MAC array:
// ROM address/read data plus the valid/ready row stream with pass markers.
interface wf_fetch_ctrl_if #(
    parameter int D_WL      = 24,
    parameter int UNITS_NUM = 5,
    parameter int AW        = 8
);
    logic [AW-1:0]             wf_addr;
    logic [UNITS_NUM*D_WL-1:0] wf_w_i;
    logic                      w_valid;
    logic                      w_ready;
    logic [UNITS_NUM*D_WL-1:0] w_data;
    logic                      w_last;
    logic                      w_job_last;

    modport master (
        output wf_addr, w_valid, w_data, w_last, w_job_last,
        input  wf_w_i, w_ready
    );

    modport slave (
        input  wf_addr, w_valid, w_data, w_last, w_job_last,
        output wf_w_i, w_ready
    );
endinterface

// File: rtl/wf_fetch_ctrl.sv
// Weight ROM sequencer: walks row_len rows from base_addr, num_pass times, into a registered row stage.
// Latency: start at edge 0, first row valid after edge 1, one row per cycle; done 1 cycle after last handshake.
// Backpressure: the row stage holds while w_valid && !w_ready; address and counters freeze with it.
module wf_fetch_ctrl #(
    parameter int D_WL      = 24,
    parameter int UNITS_NUM = 5,
    parameter int DEPTH     = 156,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [7:0]    row_len,
    input  logic [7:0]    num_pass,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    wf_fetch_ctrl_if.master wf
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                    state;
    logic [AW-1:0]             addr_q;
    logic [AW-1:0]             base_q;
    logic [7:0]                row_len_q;
    logic [7:0]                num_pass_q;
    logic [7:0]                row_cnt;
    logic [7:0]                pass_cnt;
    logic                      vld_q;
    logic [UNITS_NUM*D_WL-1:0] dat_q;
    logic                      last_q;
    logic                      job_last_q;

    logic          cap;
    logic          last_row;
    logic          last_pass;
    logic [AW-1:0] next_addr;

    assign cap       = !vld_q || wf.w_ready;
    assign last_row  = (row_cnt == row_len_q - 8'd1);
    assign last_pass = (pass_cnt == num_pass_q - 8'd1);
    // Wrap is absolute (modulo the ROM depth), not relative to base.
    assign next_addr = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

    assign wf.wf_addr    = addr_q;
    assign wf.w_valid    = vld_q;
    assign wf.w_data     = dat_q;
    assign wf.w_last     = last_q;
    assign wf.w_job_last = job_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            base_q     <= '0;
            row_len_q  <= '0;
            num_pass_q <= '0;
            row_cnt    <= '0;
            pass_cnt   <= '0;
            vld_q      <= 1'b0;
            dat_q      <= '0;
            last_q     <= 1'b0;
            job_last_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort outranks any handshake on the same edge; the row in flight is dropped.
            if (state != IDLE && abort) begin
                state    <= IDLE;
                vld_q    <= 1'b0;
                row_cnt  <= '0;
                pass_cnt <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            base_q     <= base_addr;
                            row_len_q  <= row_len;
                            num_pass_q <= num_pass;
                            addr_q     <= base_addr;
                            row_cnt    <= '0;
                            pass_cnt   <= '0;
                            if (row_len == 8'd0 || num_pass == 8'd0) begin
                                done <= 1'b1;
                            end else begin
                                state <= FETCH;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        if (cap) begin
                            vld_q      <= 1'b1;
                            dat_q      <= wf.wf_w_i;
                            last_q     <= last_row;
                            job_last_q <= last_row && last_pass;
                            if (last_row) begin
                                addr_q   <= base_q;
                                row_cnt  <= '0;
                                pass_cnt <= pass_cnt + 8'd1;
                                if (last_pass) begin
                                    state <= DRAIN;
                                end
                            end else begin
                                addr_q  <= next_addr;
                                row_cnt <= row_cnt + 8'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (vld_q && wf.w_ready) begin
                            vld_q <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wf_fetch_ctrl.sv
// Randomized bench for wf_fetch_ctrl: expected row stream is built from the job parameters as a queue
// of (address, last, job_last) and compared at every handshake; ROM content is a fixed hash of the address.
module tb_wf_fetch_ctrl;
    localparam int W     = 120;
    localparam int DEPTH = 156;

    typedef struct packed {
        logic [7:0] addr;
        logic       last;
        logic       jlast;
    } row_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] row_len;
    logic [7:0] num_pass;
    logic       abort;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    row_t exp_q[$];

    wf_fetch_ctrl_if bus ();

    wf_fetch_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .row_len   (row_len),
        .num_pass  (num_pass),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .wf        (bus)
    );

    function automatic logic [W-1:0] rom_row(input logic [7:0] a);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[k*24 +: 24] = {a, 8'(k), a ^ 8'(k * 37 + 91)};
        end
        return r;
    endfunction

    assign bus.wf_w_i = rom_row(bus.wf_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // mode 0: ready always high; 1: random ready plus ignored starts; 2: three stalls on row index 1
    task automatic run_job(input int base, input int len, input int np, input int mode,
                           input bit abort_row1, input bit abort_start);
        int   cyc;
        int   hs;
        int   stalls;
        int   budget;
        bit   fin;
        bit   degen;
        bit   hold_chk;
        logic [W-1:0] held;
        row_t e;

        degen    = (len == 0 || np == 0);
        hs       = 0;
        stalls   = 0;
        fin      = 0;
        hold_chk = 0;
        held     = '0;
        budget   = len * np * 6 + 20;
        exp_q.delete();
        for (int p = 0; p < np; p++) begin
            for (int r = 0; r < len; r++) begin
                e.addr  = 8'((base + r) % DEPTH);
                e.last  = (r == len - 1);
                e.jlast = (r == len - 1) && (p == np - 1);
                exp_q.push_back(e);
            end
        end

        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'(base);
        row_len   = 8'(len);
        num_pass  = 8'(np);
        abort     = abort_start;

        for (cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            chk("done", 128'(done), 128'(fin || (degen && cyc == 1)));
            chk("busy", 128'(busy), 128'(!degen && !fin));
            if (degen) begin
                chk("degen_vld", 128'(bus.w_valid), 128'(0));
                if (cyc == 3) break;
                continue;
            end
            if (fin) begin
                if (mode == 0) chk("done_cycle", 128'(cyc), 128'(len * np + 2));
                if (mode == 2) chk("done_cycle_bp", 128'(cyc), 128'(len * np + 5));
                break;
            end
            if (cyc == 2 && mode != 1) chk("first_vld", 128'(bus.w_valid), 128'(1));
            if (hold_chk) begin
                chk("hold_vld", 128'(bus.w_valid), 128'(1));
                chk("hold_dat", 128'(bus.w_data), 128'(held));
            end
            if (abort_row1 && bus.w_valid && hs == 1) begin
                abort       = 1'b1;
                bus.w_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_vld", 128'(bus.w_valid), 128'(0));
                chk("abort_busy", 128'(busy), 128'(0));
                for (int i = 0; i < 4; i++) begin
                    chk("abort_done", 128'(done), 128'(0));
                    @(negedge clk);
                end
                return;
            end
            case (mode)
                0: bus.w_ready = 1'b1;
                1: bus.w_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    bus.w_ready = !(bus.w_valid && hs == 1 && stalls < 3);
                    if (!bus.w_ready) stalls++;
                end
            endcase
            if (mode == 1) begin
                start     = ($urandom_range(0, 3) == 0);
                base_addr = 8'($urandom_range(0, DEPTH - 1));
                row_len   = 8'($urandom_range(0, 9));
                num_pass  = 8'($urandom_range(0, 4));
            end
            hold_chk = bus.w_valid && !bus.w_ready;
            held     = bus.w_data;
            if (bus.w_valid && bus.w_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_row", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("row_dat", 128'(bus.w_data), 128'(rom_row(e.addr)));
                    chk("row_last", 128'(bus.w_last), 128'(e.last));
                    chk("row_jlast", 128'(bus.w_job_last), 128'(e.jlast));
                    hs++;
                    if (exp_q.size() == 0) fin = 1;
                end
            end
        end
        if (cyc > budget) chk("timeout", 128'(0), 128'(1));
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        base_addr   = '0;
        row_len     = '0;
        num_pass    = '0;
        bus.w_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_addr", 128'(bus.wf_addr), 128'(0));
        chk("rst_vld", 128'(bus.w_valid), 128'(0));
        chk("rst_dat", 128'(bus.w_data), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_job(0, 3, 1, 0, 0, 0);
        run_job(0, 3, 1, 2, 0, 0);
        run_job(154, 4, 1, 0, 0, 0);
        run_job(10, 2, 3, 0, 0, 0);
        run_job(5, 0, 3, 0, 0, 0);
        run_job(5, 4, 0, 0, 0, 0);
        run_job(0, 8, 1, 0, 1, 0);
        run_job(0, 8, 1, 0, 0, 0);
        run_job(30, 3, 2, 0, 0, 1);

        // asynchronous reset in the middle of a job
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'd20;
        row_len   = 8'd5;
        num_pass  = 8'd2;
        bus.w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", 128'(bus.wf_addr), 128'(0));
        chk("arst_vld", 128'(bus.w_valid), 128'(0));
        chk("arst_dat", 128'(bus.w_data), 128'(0));
        chk("arst_last", 128'({bus.w_last, bus.w_job_last}), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", 128'(done), 128'(0));
            chk("post_rst_vld", 128'(bus.w_valid), 128'(0));
        end

        run_job(150, 5, 2, 0, 0, 0);
        for (int j = 0; j < 10; j++) begin
            run_job((j % 3 == 0) ? int'($urandom_range(148, DEPTH - 1)) : int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(1, 7)), int'($urandom_range(1, 3)), 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wf_fetch_ctrl.md
Name: wf_fetch_ctrl

Overview:
Sequencer for the LSTM weight ROM (156 rows × UNITS_NUM×D_WL bits, combinational read on an 8-bit address). Given a base row, a row count and a pass count (one pass per timestep), it drives the ROM address and registers each row into a valid/ready output stage that feeds the MAC array. Per-pass and end-of-job markers let the datapath close accumulations. It sits between the layer sequencer (start/done) and the weight ROM / MAC datapath.

Parameters:
D_WL, 24, weight word width in bits
UNITS_NUM, 5, words per ROM row
DEPTH, 156, number of ROM rows; address wraps modulo DEPTH
AW, 8, ROM address width

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
base_addr  in  AW  first row of the job; latched on an accepted start
row_len  in  8  rows per pass; latched on an accepted start
num_pass  in  8  number of passes; latched on an accepted start
abort  in  1  synchronous flush back to IDLE
wf_addr  out  AW  ROM address (registered)
wf_w_i  in  UNITS_NUM*D_WL  ROM read data for wf_addr (combinational in the ROM)
w_valid  out  1  w_data holds a row
w_ready  in  1  consumer accepts the row
w_data  out  UNITS_NUM*D_WL  registered ROM row
w_last  out  1  w_data is the final row of the current pass
w_job_last  out  1  w_data is the final row of the final pass
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; wf_addr=0, w_valid=0, w_data=0, w_last=0, w_job_last=0, busy=0, done=0; row and pass counters cleared. Reset mid-job discards the job with no done pulse.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 latches base_addr, row_len, num_pass and loads wf_addr=base_addr.
  - If row_len==0 or num_pass==0: stay in IDLE, pulse done on the next cycle, emit no rows.
  - Otherwise go to FETCH.
  - start while busy is ignored.
- FETCH:
  - Define cap = !w_valid || w_ready. When cap=1: w_data<=wf_w_i, w_valid<=1, and w_last and w_job_last are set per the counters.
  - On the same edge the address advances: wf_addr<=(wf_addr==DEPTH-1)?0:wf_addr+1. At the end of a pass it reloads base_addr instead, the row counter resets and the pass counter increments.
  - When the final row of the final pass is captured, go to DRAIN. If cap=0, hold address, counters and output stage.
- DRAIN: wait for w_valid && w_ready on the job-last row. On that edge w_valid<=0, done pulses one cycle later, state returns to IDLE.
- Latency and throughput:
  - start sampled at edge 0; wf_addr=base from edge 0; first w_valid high after edge 1.
  - With w_ready held high, one row per cycle and no bubbles, including across pass boundaries.
  - done occurs 1 cycle after the final handshake.
- Output-stage rule: w_data, w_last and w_job_last are stable while w_valid && !w_ready.
- Wrap-around: row following DEPTH-1 is 0, within a pass and independent of base.
- abort=1 in any non-IDLE state: next edge goes to IDLE with w_valid=0 and counters cleared, no done. abort has priority over a simultaneous handshake. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Counters are 8 bits, so a job is at most 255×255 rows; no saturation logic.

Test Plan:
- Basic: base=0, row_len=3, num_pass=1, w_ready=1 -> w_data=row0,row1,row2 on consecutive cycles starting 2 cycles after start. w_last=w_job_last=1 only on row2; done pulses 1 cycle after the row2 handshake; busy falls with done.
- Backpressure: same job with w_ready=0 for 3 cycles while row1 is presented -> row1 held stable; no skipped or duplicated rows; done is delayed by exactly 3 cycles.
- Wrap: base=154, row_len=4 -> addresses 154,155,0,1 and matching rows.
- Multi-pass: base=10, row_len=2, num_pass=3 -> sequence 10,11,10,11,10,11 with no gaps. w_last on every "11"; w_job_last only on the last "11".
- Degenerate: row_len=0 (or num_pass=0) -> w_valid stays 0, done pulses 1 cycle after start, busy remains 0.
- Abort and reset: abort on the 2nd row of base=0, row_len=8 -> w_valid=0 next cycle, no done, and a new start is accepted normally. rst_n low mid-job -> all outputs zero immediately and no done.
